// File: rtl/video_mnist_color_ctl.sv
// video_mnist_color_ctl: WISHBONE control block for the MNIST colour-overlay core.
// Host writes shadow mode/threshold; they reach the core only at a video frame start,
// so a frame never shows mixed settings. Optional auto-cycle steps the mode every N frames.
// Build option: define VIDEO_MNIST_COLOR_CTL_TIMEOUT_EN to force a pending update after
// TIMEOUT_CYCLES clocks without a frame start (sticky STATUS bit1).

module video_mnist_color_ctl #(
  parameter int unsigned                WB_ADR_WIDTH    = 3,
  parameter int unsigned                WB_DAT_WIDTH    = 32,
  parameter int unsigned                TCOUNT_WIDTH    = 4,
  parameter int unsigned                FRAME_CNT_WIDTH = 16,
  parameter logic [1:0]                 INIT_MODE       = 2'b00,
  parameter logic [TCOUNT_WIDTH-1:0]    INIT_TH         = '0,
  parameter int unsigned                TIMEOUT_CYCLES  = 1 << 24
) (
  input  logic                          aresetn,
  input  logic                          aclk,

  input  logic [WB_ADR_WIDTH-1:0]       s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]       s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]       s_wb_dat_o,
  input  logic                          s_wb_we_i,
  input  logic [WB_DAT_WIDTH/8-1:0]     s_wb_sel_i,
  input  logic                          s_wb_stb_i,
  output logic                          s_wb_ack_o,

  input  logic                          mon_tuser,
  input  logic                          mon_tvalid,
  input  logic                          mon_tready,

  output logic [1:0]                    param_mode,
  output logic [TCOUNT_WIDTH-1:0]       param_th,
  output logic                          frame_start
);

  localparam logic [WB_ADR_WIDTH-1:0] AdrControl = WB_ADR_WIDTH'(0);
  localparam logic [WB_ADR_WIDTH-1:0] AdrMode    = WB_ADR_WIDTH'(1);
  localparam logic [WB_ADR_WIDTH-1:0] AdrTh      = WB_ADR_WIDTH'(2);
  localparam logic [WB_ADR_WIDTH-1:0] AdrCycle   = WB_ADR_WIDTH'(3);
  localparam logic [WB_ADR_WIDTH-1:0] AdrStatus  = WB_ADR_WIDTH'(4);
  localparam logic [WB_ADR_WIDTH-1:0] AdrActive  = WB_ADR_WIDTH'(5);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e                     state_q;
  logic                       auto_en_q;
  logic [1:0]                 mode_sh_q;
  logic [TCOUNT_WIDTH-1:0]    th_sh_q;
  logic [FRAME_CNT_WIDTH-1:0] cycle_q;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;

  logic fs_beat;
  logic wr_en;
  logic rd_en;
  logic ctrl_wr;
  logic req_set;
  logic pending;
  logic apply;
  logic apply_tmo;
  logic tmo_flag;
  logic cycle_step;

  logic [FRAME_CNT_WIDTH:0] cnt_inc;
  logic [FRAME_CNT_WIDTH:0] cycle_eff;
  logic [31:0]              rd_word;

  assign fs_beat    = mon_tuser & mon_tvalid & mon_tready;
  assign wr_en      = s_wb_stb_i & s_wb_we_i;
  assign rd_en      = s_wb_stb_i & ~s_wb_we_i;
  assign s_wb_ack_o = s_wb_stb_i;

  // CONTROL is only byte 0; a write of 0 to UPDATE_REQ never cancels a pending request.
  assign ctrl_wr = wr_en && (s_wb_adr_i == AdrControl) && s_wb_sel_i[0];
  assign req_set = ctrl_wr & s_wb_dat_i[0];

  assign pending = (state_q == StPending);

  // A request landing on a frame-start beat while idle waits for the next frame start.
  assign apply = (pending & fs_beat) | apply_tmo;

  // CYCLE_FRAMES of 0 behaves like 1; compare one bit wider so counter+1 cannot wrap.
  assign cnt_inc    = {1'b0, frame_cnt_q} + (FRAME_CNT_WIDTH + 1)'(1);
  assign cycle_eff  = (cycle_q == '0) ? (FRAME_CNT_WIDTH + 1)'(1) : {1'b0, cycle_q};
  assign cycle_step = (cnt_inc >= cycle_eff);

`ifdef VIDEO_MNIST_COLOR_CTL_TIMEOUT_EN
  localparam int unsigned     TmoW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            tmo_flag_q;

  assign apply_tmo = pending && !fs_beat && (tmo_cnt_q == TmoLast);
  assign tmo_flag  = tmo_flag_q;

  // Count pending cycles; the last one forces the apply and latches the sticky flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (pending && !fs_beat && !apply_tmo) begin
        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
      end else begin
        tmo_cnt_q <= '0;
      end
      if (apply_tmo) begin
        tmo_flag_q <= 1'b1;
      end else if (ctrl_wr && s_wb_dat_i[2]) begin
        tmo_flag_q <= 1'b0;
      end
    end
  end
`else
  assign apply_tmo = 1'b0;
  assign tmo_flag  = 1'b0;
`endif

  // Host-writable configuration registers, byte-lane masked by s_wb_sel_i.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      auto_en_q <= 1'b0;
      mode_sh_q <= INIT_MODE;
      th_sh_q   <= INIT_TH;
      cycle_q   <= FRAME_CNT_WIDTH'(1);
    end else if (wr_en) begin
      case (s_wb_adr_i)
        AdrControl: begin
          if (s_wb_sel_i[0]) auto_en_q <= s_wb_dat_i[1];
        end
        AdrMode: begin
          if (s_wb_sel_i[0]) mode_sh_q <= s_wb_dat_i[1:0];
        end
        AdrTh: begin
          for (int i = 0; i < int'(TCOUNT_WIDTH); i++) begin
            if (s_wb_sel_i[i/8]) th_sh_q[i] <= s_wb_dat_i[i];
          end
        end
        AdrCycle: begin
          for (int i = 0; i < int'(FRAME_CNT_WIDTH); i++) begin
            if (s_wb_sel_i[i/8]) cycle_q[i] <= s_wb_dat_i[i];
          end
        end
        default: ;
      endcase
    end
  end

  // Update FSM plus the registered core-facing outputs and the auto-cycle frame counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      param_mode  <= INIT_MODE;
      param_th    <= INIT_TH;
      frame_cnt_q <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= fs_beat;

      unique case (state_q)
        StIdle:    if (req_set) state_q <= StPending;
        StPending: if (apply)   state_q <= StIdle;
        default:                state_q <= StIdle;
      endcase

      // A host update outranks the auto-cycle step on the same frame.
      if (apply) begin
        param_mode <= mode_sh_q;
        param_th   <= th_sh_q;
      end else if (auto_en_q && fs_beat && cycle_step) begin
        param_mode <= param_mode + 2'd1;
      end

      if (!auto_en_q || apply) begin
        frame_cnt_q <= '0;
      end else if (fs_beat) begin
        frame_cnt_q <= cycle_step ? '0 : cnt_inc[FRAME_CNT_WIDTH-1:0];
      end
    end
  end

  // Zero-wait read mux; drives 0 whenever no read is strobed.
  always_comb begin
    rd_word = '0;
    case (s_wb_adr_i)
      AdrControl: rd_word[1:0] = {auto_en_q, pending};
      AdrMode:    rd_word[1:0] = mode_sh_q;
      AdrTh:      rd_word[TCOUNT_WIDTH-1:0] = th_sh_q;
      AdrCycle:   rd_word[FRAME_CNT_WIDTH-1:0] = cycle_q;
      AdrStatus: begin
        rd_word[0]     = pending;
        rd_word[1]     = tmo_flag;
        rd_word[31:16] = 16'(frame_cnt_q);
      end
      AdrActive: begin
        rd_word[1:0]  = param_mode;
        rd_word[15:8] = 8'(param_th);
      end
      default: rd_word = '0;
    endcase
    s_wb_dat_o = rd_en ? WB_DAT_WIDTH'(rd_word) : '0;
  end

  // Upper data/select lanes carry no register bits.
  logic unused_wb;
  assign unused_wb = ^{s_wb_dat_i, s_wb_sel_i};

endmodule

// File: tb/tb_video_mnist_color_ctl.sv
// Directed self-checking bench for video_mnist_color_ctl (default build, no timeout).

module tb_video_mnist_color_ctl;

  localparam logic [1:0] InitMode = 2'b01;
  localparam logic [3:0] InitTh   = 4'd2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [2:0]  s_wb_adr_i = '0;
  logic [31:0] s_wb_dat_i = '0;
  logic [31:0] s_wb_dat_o;
  logic        s_wb_we_i = 1'b0;
  logic [3:0]  s_wb_sel_i = '0;
  logic        s_wb_stb_i = 1'b0;
  logic        s_wb_ack_o;
  logic        mon_tuser = 1'b0;
  logic        mon_tvalid = 1'b0;
  logic        mon_tready = 1'b0;
  logic [1:0]  param_mode;
  logic [3:0]  param_th;
  logic        frame_start;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] rd;

  video_mnist_color_ctl #(
    .WB_ADR_WIDTH    (3),
    .WB_DAT_WIDTH    (32),
    .TCOUNT_WIDTH    (4),
    .FRAME_CNT_WIDTH (16),
    .INIT_MODE       (InitMode),
    .INIT_TH         (InitTh),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .aresetn     (aresetn),
    .aclk        (aclk),
    .s_wb_adr_i  (s_wb_adr_i),
    .s_wb_dat_i  (s_wb_dat_i),
    .s_wb_dat_o  (s_wb_dat_o),
    .s_wb_we_i   (s_wb_we_i),
    .s_wb_sel_i  (s_wb_sel_i),
    .s_wb_stb_i  (s_wb_stb_i),
    .s_wb_ack_o  (s_wb_ack_o),
    .mon_tuser   (mon_tuser),
    .mon_tvalid  (mon_tvalid),
    .mon_tready  (mon_tready),
    .param_mode  (param_mode),
    .param_th    (param_th),
    .frame_start (frame_start)
  );

  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single write spanning one rising edge; called at a falling edge.
  task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    s_wb_adr_i = adr;
    s_wb_dat_i = dat;
    s_wb_sel_i = sel;
    s_wb_we_i  = 1'b1;
    s_wb_stb_i = 1'b1;
    @(negedge aclk);
    s_wb_stb_i = 1'b0;
    s_wb_we_i  = 1'b0;
    s_wb_sel_i = '0;
    s_wb_dat_i = '0;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] adr, input logic [31:0] exp);
    s_wb_adr_i = adr;
    s_wb_we_i  = 1'b0;
    s_wb_stb_i = 1'b1;
    #1;
    rd = s_wb_dat_o;
    s_wb_stb_i = 1'b0;
    check_eq(tag, rd, exp);
  endtask

  task automatic beat();
    mon_tuser  = 1'b1;
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    @(negedge aclk);
    mon_tuser  = 1'b0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] m, input logic [3:0] t);
    check_eq(tag, 32'({param_th, param_mode}), 32'({t, m}));
  endtask

  logic [1:0] exp_seq [6];

  initial begin
    exp_seq = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};

    // Reset values
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk_out("rst_out", InitMode, InitTh);
    check_eq("rst_fs", 32'(frame_start), 32'd0);
    check_eq("rst_dat_idle", s_wb_dat_o, 32'd0);
    check_eq("ack_idle", 32'(s_wb_ack_o), 32'd0);
    s_wb_stb_i = 1'b1;
    #1;
    check_eq("ack_stb", 32'(s_wb_ack_o), 32'd1);
    s_wb_stb_i = 1'b0;
    chk_reg("rst_ctrl", 3'd0, 32'd0);
    chk_reg("rst_mode", 3'd1, 32'(InitMode));
    chk_reg("rst_th", 3'd2, 32'(InitTh));
    chk_reg("rst_cycle", 3'd3, 32'd1);
    chk_reg("rst_status", 3'd4, 32'd0);
    chk_reg("rst_active", 3'd5, 32'h0000_0201);
    chk_reg("unmapped6", 3'd6, 32'd0);

    // Shadow writes held until a frame start
    @(negedge aclk);
    wb_write(3'd1, 32'd3, 4'hF);
    wb_write(3'd2, 32'd5, 4'hF);
    wb_write(3'd0, 32'd1, 4'hF);
    repeat (100) @(negedge aclk);
    chk_out("hold_100", InitMode, InitTh);
    chk_reg("pend_status", 3'd4, 32'd1);
    chk_reg("pend_ctrl", 3'd0, 32'd1);
    mon_tuser = 1'b1; mon_tvalid = 1'b1; mon_tready = 1'b0;
    @(negedge aclk);
    mon_tuser = 1'b0; mon_tvalid = 1'b0;
    chk_out("no_ready", InitMode, InitTh);
    check_eq("no_ready_fs", 32'(frame_start), 32'd0);
    beat();
    chk_out("apply1", 2'd3, 4'd5);
    check_eq("fs_pulse", 32'(frame_start), 32'd1);
    chk_reg("apply1_status", 3'd4, 32'd0);
    chk_reg("apply1_active", 3'd5, 32'h0000_0503);
    @(negedge aclk);
    check_eq("fs_low", 32'(frame_start), 32'd0);

    // Byte selects
    wb_write(3'd2, 32'd9, 4'h0);
    chk_reg("th_sel0", 3'd2, 32'd5);
    wb_write(3'd3, 32'h0000_0302, 4'h1);
    chk_reg("cyc_lane0", 3'd3, 32'h0000_0002);
    wb_write(3'd3, 32'h0000_0100, 4'h2);
    chk_reg("cyc_lane1", 3'd3, 32'h0000_0102);

    // Request in the same cycle as a frame start waits for the next one
    wb_write(3'd1, 32'd2, 4'hF);
    wb_write(3'd2, 32'd7, 4'hF);
    s_wb_adr_i = 3'd0; s_wb_dat_i = 32'd1; s_wb_sel_i = 4'hF;
    s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
    mon_tuser = 1'b1; mon_tvalid = 1'b1; mon_tready = 1'b1;
    @(negedge aclk);
    s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0; s_wb_sel_i = '0; s_wb_dat_i = '0;
    mon_tuser = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
    chk_out("same_cyc_hold", 2'd3, 4'd5);
    chk_reg("same_cyc_pend", 3'd4, 32'd1);
    beat();
    chk_out("same_cyc_apply", 2'd2, 4'd7);

    // Auto-cycle, period 2, starting from mode 3
    wb_write(3'd1, 32'd3, 4'hF);
    wb_write(3'd0, 32'd1, 4'hF);
    beat();
    chk_out("pre_auto", 2'd3, 4'd7);
    wb_write(3'd3, 32'd2, 4'hF);
    wb_write(3'd0, 32'd2, 4'hF);
    for (int i = 0; i < 6; i++) begin
      beat();
      chk_out($sformatf("auto_f%0d", i + 1), exp_seq[i], 4'd7);
      if (i == 0) chk_reg("auto_cnt1", 3'd4, 32'h0001_0000);
    end

    // Pending update landing on a step frame wins; counter cleared
    beat();
    chk_reg("cnt_before", 3'd4, 32'h0001_0000);
    wb_write(3'd1, 32'd1, 4'hF);
    wb_write(3'd0, 32'd3, 4'hF);
    chk_reg("auto_pend", 3'd4, 32'h0001_0001);
    beat();
    chk_out("prio_apply", 2'd1, 4'd7);
    chk_reg("prio_cnt0", 3'd4, 32'd0);
    beat();
    chk_out("prio_next", 2'd1, 4'd7);
    beat();
    chk_out("prio_step", 2'd2, 4'd7);

    // AUTO_EN off freezes mode and clears the counter
    beat();
    wb_write(3'd0, 32'd0, 4'hF);
    @(negedge aclk);
    chk_reg("auto_off_cnt", 3'd4, 32'd0);
    beat();
    beat();
    chk_out("auto_off_frozen", 2'd2, 4'd7);
    chk_reg("auto_off_hold0", 3'd4, 32'd0);

    // CYCLE_FRAMES = 0 steps every frame
    wb_write(3'd3, 32'd0, 4'hF);
    chk_reg("cyc_zero", 3'd3, 32'd0);
    wb_write(3'd0, 32'd2, 4'hF);
    beat();
    chk_out("cyc0_f1", 2'd3, 4'd7);
    beat();
    chk_out("cyc0_f2", 2'd0, 4'd7);
    wb_write(3'd0, 32'd0, 4'hF);

    // Re-request and late shadow write while pending
    wb_write(3'd1, 32'd1, 4'hF);
    wb_write(3'd0, 32'd1, 4'hF);
    wb_write(3'd0, 32'd1, 4'hF);
    wb_write(3'd1, 32'd2, 4'hF);
    wb_write(3'd0, 32'd0, 4'hF);
    chk_reg("rereq_pend", 3'd0, 32'd1);
    beat();
    chk_out("latest_wins", 2'd2, 4'd7);
    chk_reg("rereq_idle", 3'd0, 32'd0);
    beat();
    chk_out("no_reapply", 2'd2, 4'd7);

    // Reset mid-operation discards a pending request
    wb_write(3'd1, 32'd3, 4'hF);
    wb_write(3'd0, 32'd1, 4'hF);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    chk_out("rst2_out", InitMode, InitTh);
    chk_reg("rst2_status", 3'd4, 32'd0);
    chk_reg("rst2_mode", 3'd1, 32'(InitMode));
    chk_reg("rst2_cycle", 3'd3, 32'd1);
    beat();
    chk_out("rst2_no_apply", InitMode, InitTh);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
